// File: rtl/riscv_pc_alu_dmem.sv
// Execution and memory core of the single-cycle RV32 datapath.
// It holds three independent blocks behind one boundary:
//   - the program counter register, which steps by PC_STEP every clock;
//   - a combinational 32-bit ALU with a zero flag;
//   - a word-wide data memory with synchronous write and combinational read.
// Decode, the register file, instruction memory and immediate extension
// drive these ports from outside this module.

module riscv_pc_alu_dmem #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          PC_STEP    = 4,
  parameter int          DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_reg,
  input  logic [3:0]  alu_ctl,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] alu_out,
  output logic        zero,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data
);

  // Word index width. DMEM_WORDS is a power of two, so the index is a clean
  // slice of the byte address.
  localparam int          IDX_W     = $clog2(DMEM_WORDS);
  localparam logic [31:0] PC_STEP_C = 32'(PC_STEP);

  // ALU operation codes. The low three bits match RV32 funct3, and bit 3
  // selects the alternate form (SUB, SRA).
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b1000;
  localparam logic [3:0] OP_SLL  = 4'b0001;
  localparam logic [3:0] OP_SLT  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SRA  = 4'b1101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_AND  = 4'b0111;

  logic [31:0]      pc_r;
  logic [31:0]      alu_s;
  logic [4:0]       shamt_s;
  logic [IDX_W-1:0] idx_s;
  logic [31:0]      rd_s;
  logic             unused_addr_s;

  // Every word starts at zero, so simulation begins from known contents.
  // Reset never clears this array.
  logic [31:0] mem_r [DMEM_WORDS] = '{default: 32'h0000_0000};

  // ---------------------------------------------------------------------
  // Program counter
  // ---------------------------------------------------------------------

  // Program counter: forced to RESET_PC while reset is high, otherwise it
  // steps every edge and wraps modulo 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_r <= RESET_PC;
    end else begin
      pc_r <= pc_r + PC_STEP_C;
    end
  end

  assign pc_reg = pc_r;

  // ---------------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------------

  // Shift amounts use only the low five bits of b, as RV32 does.
  assign shamt_s = b[4:0];

  // ALU result selection. Unused codes give zero.
  always_comb begin
    alu_s = 32'h0000_0000;
    case (alu_ctl)
      OP_ADD:  alu_s = a + b;
      OP_SUB:  alu_s = a - b;
      OP_SLL:  alu_s = a << shamt_s;
      OP_SLT:  alu_s = ($signed(a) < $signed(b)) ? 32'h0000_0001 : 32'h0000_0000;
      OP_SLTU: alu_s = (a < b) ? 32'h0000_0001 : 32'h0000_0000;
      OP_XOR:  alu_s = a ^ b;
      OP_SRL:  alu_s = a >> shamt_s;
      OP_SRA:  alu_s = 32'($signed(a) >>> shamt_s);
      OP_OR:   alu_s = a | b;
      OP_AND:  alu_s = a & b;
      default: alu_s = 32'h0000_0000;
    endcase
  end

  assign alu_out = alu_s;
  assign zero    = (alu_s == 32'h0000_0000);

  // ---------------------------------------------------------------------
  // Data memory
  // ---------------------------------------------------------------------

  // The byte offset and the bits above the array size are dropped, so
  // out-of-range addresses alias onto the array.
  assign idx_s         = address[IDX_W+1:2];
  assign unused_addr_s = ^{address[31:IDX_W+2], address[1:0]};

  // Word store on the rising edge. Reset does not gate writes and has no
  // byte masking.
  always_ff @(posedge clk) begin
    if (write_enable) begin
      mem_r[idx_s] <= write_data;
    end
  end

  // Combinational load with no write forwarding, so a same-cycle write
  // appears only after the edge.
  always_comb begin
    rd_s = 32'h0000_0000;
    if (read_enable) begin
      rd_s = mem_r[idx_s];
    end else begin
      rd_s = 32'h0000_0000;
    end
  end

  assign read_data = rd_s;

endmodule

// File: tb/tb_riscv_pc_alu_dmem.sv
// Self-checking bench for riscv_pc_alu_dmem. Expected values are pushed to
// a scoreboard queue when the stimulus is driven. They are popped and
// compared once the DUT outputs have settled. A second instance with a high
// RESET_PC covers the 32-bit wrap of the program counter.

module tb_riscv_pc_alu_dmem;

  logic        clk;
  logic        reset;
  logic [31:0] pc_reg;
  logic [3:0]  alu_ctl;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] alu_out;
  logic        zero;
  logic        write_enable;
  logic        read_enable;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;

  // Outputs of the wrap-test instance
  logic [31:0] w_pc_reg;
  logic [31:0] w_alu_out;
  logic        w_zero;
  logic [31:0] w_read_data;

  int checks_cnt = 0;
  int fail_cnt   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];

  riscv_pc_alu_dmem u_dut (
    .clk          (clk),
    .reset        (reset),
    .pc_reg       (pc_reg),
    .alu_ctl      (alu_ctl),
    .a            (a),
    .b            (b),
    .alu_out      (alu_out),
    .zero         (zero),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data)
  );

  riscv_pc_alu_dmem #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk          (clk),
    .reset        (reset),
    .pc_reg       (w_pc_reg),
    .alu_ctl      (alu_ctl),
    .a            (a),
    .b            (b),
    .alu_out      (w_alu_out),
    .zero         (w_zero),
    .write_enable (1'b0),
    .read_enable  (1'b0),
    .address      (address),
    .write_data   (write_data),
    .read_data    (w_read_data)
  );

  // Free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", obs, ~obs);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, obs, e.val);
    end
  endtask

  // ALU stimulus table: ctl, a, b, expected result
  localparam int N_ALU = 15;
  logic [3:0]  t_ctl [N_ALU] = '{4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0010,
                                 4'b0011, 4'b0010, 4'b0011, 4'b1101, 4'b0101,
                                 4'b0001, 4'b0111, 4'b0110, 4'b0100, 4'b1111};
  logic [31:0] t_a   [N_ALU] = '{32'd5, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                 32'hFFFF_FFFF, 32'd1, 32'd1, 32'h8000_0000, 32'h8000_0000,
                                 32'd1, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0, 32'hF0F0_F0F0};
  logic [31:0] t_b   [N_ALU] = '{32'd7, 32'd7, 32'd1, 32'd1, 32'd1,
                                 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0024, 32'h0000_0024,
                                 32'd31, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h0FF0_0FF0, 32'h0FF0_0FF0};
  logic [31:0] t_exp [N_ALU] = '{32'd12, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd1,
                                 32'd0, 32'd0, 32'd1, 32'hF800_0000, 32'h0800_0000,
                                 32'h8000_0000, 32'h00F0_00F0, 32'hFFF0_FFF0, 32'hFF00_FF00, 32'd0};

  // Main stimulus
  initial begin
    reset        = 1'b1;
    alu_ctl      = 4'b0000;
    a            = 32'h0;
    b            = 32'h0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    address      = 32'h0;
    write_data   = 32'h0;

    // PC is held at reset across an edge
    #2;
    push_exp("pc_reset", 32'h0);
    pop_check(pc_reg);
    @(negedge clk);
    push_exp("pc_reset_held", 32'h0);
    pop_check(pc_reg);
    push_exp("pc_wrap_reset", 32'hFFFF_FFF8);
    pop_check(w_pc_reg);

    // Release reset and step the PC four times; the wrap instance crosses 0
    reset = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      push_exp($sformatf("pc_step%0d", i), 32'(4 * i));
      push_exp($sformatf("pc_wrap_step%0d", i), 32'hFFFF_FFF8 + 32'(4 * i));
      @(posedge clk);
      #1;
      pop_check(pc_reg);
      pop_check(w_pc_reg);
    end

    // Reset between edges forces RESET_PC at once
    #2;
    reset = 1'b1;
    push_exp("pc_async_reset", 32'h0);
    #1;
    pop_check(pc_reg);
    @(negedge clk);
    reset = 1'b0;
    push_exp("pc_first_after_reset", 32'h4);
    @(posedge clk);
    #1;
    pop_check(pc_reg);

    // ALU table: result and zero flag
    for (int i = 0; i < N_ALU; i++) begin
      @(negedge clk);
      alu_ctl = t_ctl[i];
      a       = t_a[i];
      b       = t_b[i];
      push_exp($sformatf("alu_out%0d", i), t_exp[i]);
      push_exp($sformatf("alu_zero%0d", i), {31'b0, (t_exp[i] == 32'h0)});
      #1;
      pop_check(alu_out);
      pop_check({31'b0, zero});
    end

    // Store DEAD_BEEF at byte address 8
    @(negedge clk);
    address      = 32'd8;
    write_data   = 32'hDEAD_BEEF;
    write_enable = 1'b1;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    read_enable  = 1'b1;
    push_exp("ld_addr8", 32'hDEAD_BEEF);
    #1;
    pop_check(read_data);
    address = 32'd9;
    push_exp("ld_addr9", 32'hDEAD_BEEF);
    #1;
    pop_check(read_data);
    read_enable = 1'b0;
    push_exp("ld_re0", 32'h0);
    #1;
    pop_check(read_data);
    read_enable = 1'b1;
    address     = 32'd8 + 32'd4 * 32'd256;
    push_exp("ld_alias", 32'hDEAD_BEEF);
    #1;
    pop_check(read_data);

    // Read during write at address 16: old word before the edge, new after
    @(negedge clk);
    address      = 32'd16;
    write_data   = 32'h1234_5678;
    write_enable = 1'b1;
    read_enable  = 1'b1;
    push_exp("rdw_before", 32'h0);
    #1;
    pop_check(read_data);
    push_exp("rdw_after", 32'h1234_5678);
    @(posedge clk);
    #1;
    pop_check(read_data);
    write_enable = 1'b0;

    // Reset leaves memory intact and does not block writes
    @(negedge clk);
    reset = 1'b1;
    push_exp("rst_keeps_16", 32'h1234_5678);
    #1;
    pop_check(read_data);
    address = 32'd8;
    push_exp("rst_keeps_8", 32'hDEAD_BEEF);
    #1;
    pop_check(read_data);
    address      = 32'd20;
    write_data   = 32'hA5A5_5A5A;
    write_enable = 1'b1;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    push_exp("wr_in_reset", 32'hA5A5_5A5A);
    #1;
    pop_check(read_data);
    push_exp("pc_in_reset", 32'h0);
    pop_check(pc_reg);

    // ALU still follows its inputs while reset is high
    alu_ctl = 4'b1000;
    a       = 32'd3;
    b       = 32'd3;
    push_exp("alu_in_reset", 32'h0);
    push_exp("zero_in_reset", 32'h1);
    #1;
    pop_check(alu_out);
    pop_check({31'b0, zero});

    if (sb_q.size() != 0) begin
      check_val("sb_leftover", 32'(sb_q.size()), 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/riscv_pc_alu_dmem.md
Name: riscv_pc_alu_dmem

Overview:
- Execution and memory core of the single-cycle RV32 datapath.
- Contains three independent sub-functions behind one boundary:
  - program counter register;
  - 32-bit integer ALU with zero flag;
  - word-wide data memory with synchronous write and combinational read.
- Decode/control logic, register file, instruction memory and immediate extension drive these ports from outside.

Parameters:
- RESET_PC, 32'h0000_0000, value loaded into pc_reg on reset.
- PC_STEP, 4, byte increment applied to pc_reg every clock.
- DMEM_WORDS, 256, number of 32-bit words in the data memory (power of two).

Ports:
- clk  input  1  rising-edge clock for PC and memory writes.
- reset  input  1  asynchronous, active-high reset.
- pc_reg  output  32  current program counter (byte address).
- alu_ctl  input  4  ALU operation select.
- a  input  32  ALU operand A.
- b  input  32  ALU operand B.
- alu_out  output  32  ALU result.
- zero  output  1  high when alu_out == 0.
- write_enable  input  1  data memory write strobe.
- read_enable  input  1  data memory read enable.
- address  input  32  data memory byte address.
- write_data  input  32  data to store.
- read_data  output  32  loaded data.

Behaviour:

PC:
- On reset assertion, pc_reg = RESET_PC immediately, independent of clk.
- While reset is low, each rising clk edge: pc_reg <= pc_reg + PC_STEP, modulo 2^32 (32'hFFFF_FFFC + 4 wraps to 0).
- Reset asserted mid-run forces RESET_PC at once. The first edge after deassertion yields RESET_PC + PC_STEP.

ALU:
- Purely combinational; no clock or reset dependency.
- Encoding (low three bits equal RV32 funct3; bit 3 selects the alternate form):
  - 0000 ADD a+b, modulo 2^32.
  - 1000 SUB a-b, modulo 2^32.
  - 0001 SLL a << b[4:0].
  - 0010 SLT: 1 if signed(a) < signed(b), else 0.
  - 0011 SLTU: 1 if unsigned a < unsigned b, else 0.
  - 0100 XOR.
  - 0101 SRL: logical a >> b[4:0].
  - 1101 SRA: arithmetic a >>> b[4:0].
  - 0110 OR.
  - 0111 AND.
  - Any other code: alu_out = 0.
- Shift amounts use only b[4:0]; b[31:5] are ignored.
- No overflow or carry outputs.
- zero reflects alu_out combinationally.

Data memory:
- Storage is DMEM_WORDS x 32 bits.
- Word index = address[log2(DMEM_WORDS)+1 : 2]. address[1:0] and all higher bits are ignored, so out-of-range addresses alias modulo the array size.
- Write:
  - On rising clk edge with write_enable=1, mem[index] <= write_data.
  - No byte or halfword masking.
- Read:
  - Combinational: read_data = mem[index] when read_enable=1, else 32'h0.
- read_enable and write_enable both high on the same address:
  - read_data shows the old word before the edge and the new word after it.
  - No write-through forwarding.
- Reset:
  - Does not modify memory contents and does not block writes.
  - At time zero every word is initialised to 0 so simulation starts from known contents.
  - Reset has no effect on read_data other than through read_enable.

Outputs during reset:
- pc_reg = RESET_PC.
- alu_out and zero follow their inputs.
- read_data follows read_enable and memory contents.

Test Plan:
- PC sequence: assert reset, then release and give 4 clocks -> pc_reg reads 0 during reset, then 4, 8, 12, 16. Re-assert reset between edges -> pc_reg = 0 immediately, without waiting for a clock edge.
- ADD/SUB/zero:
  - alu_ctl=0000, a=5, b=7 -> 12, zero=0.
  - alu_ctl=1000, a=7, b=7 -> 0, zero=1.
  - alu_ctl=1000, a=0, b=1 -> 32'hFFFF_FFFF.
- Compare and shift:
  - SLT a=32'hFFFF_FFFF, b=1 -> 1; SLTU with same operands -> 0.
  - SRA a=32'h8000_0000, b=32'h0000_0024 -> 32'hF800_0000 (shift amount 4).
  - SRL with same operands -> 32'h0800_0000.
  - SLL a=1, b=31 -> 32'h8000_0000.
- Logic ops: a=32'hF0F0_F0F0, b=32'h0FF0_0FF0 -> AND 32'h00F0_00F0, OR 32'hFFF0_FFF0, XOR 32'hFF00_FF00. Unused code 1111 -> 0.
- Memory store/load:
  - Write 32'hDEAD_BEEF to address 8 on one edge.
  - Read address 8 with read_enable=1 -> DEAD_BEEF; address 9 also -> DEAD_BEEF (low bits ignored).
  - read_enable=0 -> 0.
  - Address 8 + 4*DMEM_WORDS aliases -> DEAD_BEEF.
- Read-during-write:
  - Hold read_enable=1 and write_enable=1 at address 16 containing 0, with write_data=32'h1234_5678.
  - read_data = 0 before the edge and 32'h1234_5678 after it.
  - Assert reset -> contents unchanged on a subsequent read.
